// File: rtl/observer_sample_sched.sv
// Trigger-driven sensor sampler: configures the SPI sensor once after reset, reads N_REGS registers per trigger,
// and streams them to the UART as uppercase ASCII hex followed by CR LF. Optional auto-sampling via `SAMPLE_TIMER_EN.
module observer_sample_sched #(
    parameter int          N_REGS    = 6,
    parameter logic [7:0]  BASE_ADDR = 8'h32,
    parameter logic [7:0]  CFG_ADDR  = 8'h2D,
    parameter logic [7:0]  CFG_DATA  = 8'h08,
    parameter int          PERIOD    = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_user_btn,
    output logic       o_spi_start,
    output logic       o_spi_wr,
    output logic [7:0] o_spi_addr,
    output logic [7:0] o_spi_wdata,
    input  logic       i_spi_done,
    input  logic [7:0] i_spi_rdata,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

    typedef enum logic [3:0] {
        INIT_REQ, INIT_WAIT, IDLE, RD_REQ, RD_WAIT, TX_HI, TX_LO, TX_CR, TX_LF
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       buf_q [N_REGS];
    logic [7:0]       buf_d [N_REGS];
    logic             spi_start_q, spi_start_d;
    logic             spi_wr_q, spi_wr_d;
    logic [7:0]       spi_addr_q, spi_addr_d;
    logic [7:0]       spi_wdata_q, spi_wdata_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             btn_meta_q, btn_sync_q, btn_prev_q;
    logic             trig_btn, trig;
    logic             tx_hs;
    logic [7:0]       cur_byte;
    logic [7:0]       tx_char;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Button is asynchronous: two-flop synchroniser, then rising-edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= i_user_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign trig_btn = btn_sync_q & ~btn_prev_q;

`ifdef SAMPLE_TIMER_EN
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             tick;

    always_comb begin
        tick  = (tmr_q == CNT_W'(PERIOD - 1));
        tmr_d = tick ? '0 : tmr_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) tmr_q <= '0;
        else          tmr_q <= tmr_d;
    end

    assign trig = trig_btn | tick;
`else
    assign trig = trig_btn;
`endif

    assign tx_hs    = tx_valid_q & i_tx_ready;
    assign cur_byte = buf_q[idx_q];

    always_comb begin
        tx_char = 8'h00;
        case (state_q)
            TX_HI:   tx_char = hex_char(cur_byte[7:4]);
            TX_LO:   tx_char = hex_char(cur_byte[3:0]);
            TX_CR:   tx_char = 8'h0D;
            TX_LF:   tx_char = 8'h0A;
            default: tx_char = 8'h00;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (state_q == RD_WAIT && i_spi_done) begin
            buf_d[idx_q] = i_spi_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spi_start_d = 1'b0;
        spi_wr_d    = spi_wr_q;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        overrun_d   = overrun_q;

        // Triggers before configuration completes are dropped silently; later ones while busy are flagged.
        if (trig && !(state_q inside {IDLE, INIT_REQ, INIT_WAIT})) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            INIT_REQ: begin
                spi_start_d = 1'b1;
                spi_wr_d    = 1'b1;
                spi_addr_d  = CFG_ADDR;
                spi_wdata_d = CFG_DATA;
                state_d     = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (i_spi_done) state_d = IDLE;
            end
            IDLE: begin
                if (trig) begin
                    idx_d   = '0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                spi_start_d = 1'b1;
                spi_wr_d    = 1'b0;
                spi_addr_d  = BASE_ADDR + 8'(idx_q);
                spi_wdata_d = 8'h00;
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                if (i_spi_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = TX_HI;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            TX_HI, TX_LO, TX_CR, TX_LF: begin
                // Valid is raised one cycle after entering, dropped on handshake, giving a gap between bytes.
                if (tx_hs) begin
                    tx_valid_d = 1'b0;
                    case (state_q)
                        TX_HI: state_d = TX_LO;
                        TX_LO: begin
                            if (idx_q < LAST_IDX) begin
                                idx_d   = idx_q + 1'b1;
                                state_d = TX_HI;
                            end else begin
                                state_d = TX_CR;
                            end
                        end
                        TX_CR:   state_d = TX_LF;
                        default: state_d = IDLE;
                    endcase
                end else if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = tx_char;
                end
            end
            default: state_d = INIT_REQ;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= INIT_REQ;
            idx_q       <= '0;
            spi_start_q <= 1'b0;
            spi_wr_q    <= 1'b0;
            spi_addr_q  <= 8'h00;
            spi_wdata_q <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spi_start_q <= spi_start_d;
            spi_wr_q    <= spi_wr_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < N_REGS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign o_spi_start = spi_start_q;
    assign o_spi_wr    = spi_wr_q;
    assign o_spi_addr  = spi_addr_q;
    assign o_spi_wdata = spi_wdata_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_busy      = busy_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_observer_sample_sched.sv
// Scoreboard bench for observer_sample_sched: SPI slave and UART sink models, expected
// SPI accesses and UART bytes queued at stimulus time and compared as the DUT produces them.
module tb_observer_sample_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       o_spi_start, o_spi_wr;
    logic [7:0] o_spi_addr, o_spi_wdata;
    logic       i_spi_done = 1'b0;
    logic [7:0] i_spi_rdata = 8'h00;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_busy, o_overrun;

    always #5 clk = ~clk;

    observer_sample_sched dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_user_btn  (btn),
        .o_spi_start (o_spi_start),
        .o_spi_wr    (o_spi_wr),
        .o_spi_addr  (o_spi_addr),
        .o_spi_wdata (o_spi_wdata),
        .i_spi_done  (i_spi_done),
        .i_spi_rdata (i_spi_rdata),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem [256];
    int         spi_dly;
    int         spi_starts = 0;
    int         tx_bytes   = 0;
    bit         pending    = 1'b0;
    int         cnt        = 0;
    logic [7:0] pend_addr  = 8'h00;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [16:0] exp_spi [$];
    logic [7:0]  exp_tx  [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string s;
        s = "0123456789ABCDEF";
        return s[n];
    endfunction

    // SPI slave, UART sink and scoreboard comparison, all sampled on the falling edge.
    always @(negedge clk) begin
        logic [16:0] got_spi, want_spi;
        logic [7:0]  want_tx;
        if (!rst_n) begin
            i_spi_done = 1'b0;
            pending    = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            exp_spi.delete();
            exp_tx.delete();
        end else begin
            i_spi_done = 1'b0;
            if (pending) begin
                if (cnt <= 1) begin
                    i_spi_done  = 1'b1;
                    i_spi_rdata = mem[pend_addr];
                    pending     = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (o_spi_start) begin
                spi_starts++;
                $display("[TB] spi start wr=%0d addr=%02h wdata=%02h", o_spi_wr, o_spi_addr, o_spi_wdata);
                check_eq("spi_overlap", 32'(pending | i_spi_done), 32'd0);
                check_eq("spi_expected", 32'(exp_spi.size() != 0), 32'd1);
                if (exp_spi.size() != 0) begin
                    want_spi = exp_spi.pop_front();
                    got_spi  = {o_spi_wr, o_spi_addr, (o_spi_wr ? o_spi_wdata : 8'h00)};
                    check_eq("spi_access", 32'(got_spi), 32'(want_spi));
                end
                pending   = 1'b1;
                cnt       = spi_dly;
                pend_addr = o_spi_addr;
            end
            if (prev_valid && !prev_ready) begin
                check_eq("tx_hold_valid", 32'(o_tx_valid), 32'd1);
                check_eq("tx_hold_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (prev_valid && prev_ready) begin
                check_eq("tx_gap", 32'(o_tx_valid), 32'd0);
            end
            if (o_tx_valid && i_tx_ready) begin
                tx_bytes++;
                $display("[TB] uart byte %02h", o_tx_data);
                check_eq("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) begin
                    want_tx = exp_tx.pop_front();
                    check_eq("tx_byte", 32'(o_tx_data), 32'(want_tx));
                end
            end
            prev_valid = o_tx_valid;
            prev_ready = i_tx_ready;
            prev_data  = o_tx_data;
        end
    end

    task automatic push_sample();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            exp_spi.push_back({1'b0, 8'(8'h32 + i), 8'h00});
        end
        for (int i = 0; i < 6; i++) begin
            b = mem[8'(8'h32 + i)];
            exp_tx.push_back(hexc(b[7:4]));
            exp_tx.push_back(hexc(b[3:0]));
        end
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
    endtask

    task automatic press();
        @(posedge clk); #1 btn = 1'b1;
        repeat (4) @(posedge clk);
        #1 btn = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        repeat (2) @(posedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!o_busy) return;
        end
        check_eq({tag, "_idle_timeout"}, 32'(o_busy), 32'd0);
    endtask

    task automatic wait_tx(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_bytes >= target) return;
        end
        check_eq("wait_tx_timeout", tx_bytes, target);
    endtask

    task automatic wait_spi(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spi_starts >= target) return;
        end
        check_eq("wait_spi_timeout", spi_starts, target);
    endtask

    task automatic load_mem(input logic [47:0] vals);
        for (int i = 0; i < 6; i++) begin
            mem[8'(8'h32 + i)] = vals[47 - 8*i -: 8];
        end
    endtask

    initial begin
        int base;
        rst_n      = 1'b0;
        btn        = 1'b0;
        i_tx_ready = 1'b1;
        spi_dly    = 5;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
        load_mem(48'h12_34_56_78_9A_BC);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_spi_start", 32'(o_spi_start), 32'd0);
        check_eq("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_overrun", 32'(o_overrun), 32'd0);
        check_eq("rst_spi_addr", 32'(o_spi_addr), 32'd0);

        // Configuration write after reset
        exp_spi.push_back({1'b1, 8'h2D, 8'h08});
        rst_n = 1'b1;
        wait_idle("cfg", 100);
        check_eq("cfg_spi_left", exp_spi.size(), 0);
        check_eq("cfg_starts", spi_starts, 1);
        check_eq("cfg_busy", 32'(o_busy), 32'd0);

        // First sample, with trigger latency check
        push_sample();
        @(posedge clk); #1 btn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("trig_lat2_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("trig_lat3_busy", 32'(o_busy), 32'd1);
        repeat (2) @(posedge clk);
        #1 btn = 1'b0;
        wait_idle("s1", 500);
        check_eq("s1_spi_left", exp_spi.size(), 0);
        check_eq("s1_tx_left", exp_tx.size(), 0);
        check_eq("s1_tx_bytes", tx_bytes, 14);
        check_eq("s1_overrun", 32'(o_overrun), 32'd0);

        // Second sample: UART stall mid-stream and a press during the UART phase
        load_mem(48'hDE_AD_0F_F0_5A_A5);
        push_sample();
        press();
        wait_tx(17, 500);
        @(posedge clk); #1 i_tx_ready = 1'b0;
        press();
        repeat (15) @(posedge clk);
        #1 i_tx_ready = 1'b1;
        wait_idle("s2", 500);
        check_eq("s2_spi_left", exp_spi.size(), 0);
        check_eq("s2_tx_left", exp_tx.size(), 0);
        check_eq("s2_tx_bytes", tx_bytes, 28);
        check_eq("s2_spi_starts", spi_starts, 13);
        check_eq("s2_overrun", 32'(o_overrun), 32'd1);

        // Reset while a read is outstanding
        base = spi_starts;
        push_sample();
        press();
        wait_spi(base + 2, 200);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_eq("arst_spi_start", 32'(o_spi_start), 32'd0);
        check_eq("arst_spi_addr", 32'(o_spi_addr), 32'd0);
        check_eq("arst_tx_valid", 32'(o_tx_valid), 32'd0);
        check_eq("arst_busy", 32'(o_busy), 32'd0);
        check_eq("arst_overrun", 32'(o_overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        base = spi_starts;
        exp_spi.push_back({1'b1, 8'h2D, 8'h08});
        rst_n = 1'b1;
        wait_idle("recfg", 100);
        check_eq("recfg_spi_left", exp_spi.size(), 0);
        check_eq("recfg_starts", spi_starts, base + 1);

        // Sample after re-configuration with a fast SPI slave
        spi_dly = 1;
        load_mem(48'h00_FF_7E_81_C3_3C);
        base = tx_bytes;
        push_sample();
        press();
        wait_idle("s3", 500);
        check_eq("s3_spi_left", exp_spi.size(), 0);
        check_eq("s3_tx_left", exp_tx.size(), 0);
        check_eq("s3_tx_bytes", tx_bytes, base + 14);
        check_eq("s3_overrun", 32'(o_overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
